instr_fetch_unit: RTL and testbench

Parametrised successor to the instruction memory/IR/PC block.
- Owns the PC, an internal writable instruction store and the IR, and fetches one instruction per cycle.
- Supports branch load, stall, pipeline bubble on redirect and an out-of-range fetch error.
- Feeds the decode stage of the datapath. The program is loaded through a separate write port.

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC, a writable instruction store and the IR; fetches one word per
// cycle into the IR for the decode stage. Supports branch redirect (one-cycle
// bubble), stall, and a sticky out-of-range fetch error.
// Optional feature macro: HALT_DETECT_EN -- when defined, fetching HALT_WORD
// freezes the fetch stage at the halt address until reset or redirect.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int unsigned       DATA_W    = 16,
   parameter int unsigned       ADDR_W    = 16,
   parameter int unsigned       DEPTH     = 256,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int unsigned       PC_STEP   = 1,
   parameter logic [DATA_W-1:0] NOP_WORD  = '0,
   parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_wr,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              pc_wr,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              stall,
   output logic [DATA_W-1:0] ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_err,
   output logic              halted
);

   // Store index width; a one-word store still needs a one-bit index.
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // DEPTH widened by one bit so DEPTH == 2^ADDR_W is representable.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_INC    = ADDR_W'(PC_STEP);

`ifdef HALT_DETECT_EN
   localparam logic HALT_EN = 1'b1;
`else
   localparam logic HALT_EN = 1'b0;
`endif

   // Instruction store (never reset: program survives rst)
   logic [DATA_W-1:0] mem_r [0:DEPTH-1];

   // Fetch-stage state
   logic [ADDR_W-1:0] pc_r;
   logic [DATA_W-1:0] ir_r;
   logic [ADDR_W-1:0] ir_pc_r;
   logic              ir_valid_r;
   logic              fetch_err_r;
   logic              halted_r;

   // Next-state values
   logic [ADDR_W-1:0] pc_nxt_s;
   logic [DATA_W-1:0] ir_nxt_s;
   logic [ADDR_W-1:0] ir_pc_nxt_s;
   logic              ir_valid_nxt_s;
   logic              fetch_err_nxt_s;
   logic              halted_nxt_s;

   // Decode helpers
   logic              fetch_in_range_s;
   logic              prog_in_range_s;
   logic [DATA_W-1:0] rd_word_s;
   logic              halt_hit_s;
   logic              hold_s;

   assign fetch_in_range_s = ({1'b0, pc_r} < DEPTH_EXT);
   assign prog_in_range_s  = ({1'b0, prog_addr} < DEPTH_EXT);
   // Asynchronous read of the current PC; only used when in range.
   assign rd_word_s        = mem_r[pc_r[IDX_W-1:0]];
   assign halt_hit_s       = HALT_EN & (rd_word_s == HALT_WORD);
   // A halted unit behaves exactly like a stalled one.
   assign hold_s           = stall | halted_r;

   // Program write port; independent of reset, stall, halt and redirect.
   // Nonblocking update gives read-before-write on a same-address fetch.
   always_ff @(posedge clk) begin
      if (prog_wr && prog_in_range_s) begin
         mem_r[prog_addr[IDX_W-1:0]] <= prog_data;
      end
   end

   // Next-state selection: redirect beats hold, hold beats normal fetch.
   always_comb begin
      pc_nxt_s        = pc_r;
      ir_nxt_s        = ir_r;
      ir_pc_nxt_s     = ir_pc_r;
      ir_valid_nxt_s  = ir_valid_r;
      fetch_err_nxt_s = fetch_err_r;
      halted_nxt_s    = halted_r;
      if (pc_wr) begin
         // Redirect: insert a bubble, keep the old IR, clear error/halt
         pc_nxt_s        = pc_in;
         ir_valid_nxt_s  = 1'b0;
         fetch_err_nxt_s = 1'b0;
         halted_nxt_s    = 1'b0;
      end else if (hold_s) begin
         // Stall or halt: everything holds (defaults)
         pc_nxt_s = pc_r;
      end else if (!fetch_in_range_s) begin
         // Fetch past the end of the store: return NOP and flag it
         ir_nxt_s        = NOP_WORD;
         ir_pc_nxt_s     = pc_r;
         ir_valid_nxt_s  = 1'b1;
         fetch_err_nxt_s = 1'b1;
         pc_nxt_s        = pc_r + PC_INC;
      end else if (halt_hit_s) begin
         // Halt word fetched: deliver it and park the PC on it
         ir_nxt_s       = rd_word_s;
         ir_pc_nxt_s    = pc_r;
         ir_valid_nxt_s = 1'b1;
         halted_nxt_s   = 1'b1;
         pc_nxt_s       = pc_r;
      end else begin
         // Normal fetch, PC wraps modulo 2^ADDR_W
         ir_nxt_s       = rd_word_s;
         ir_pc_nxt_s    = pc_r;
         ir_valid_nxt_s = 1'b1;
         pc_nxt_s       = pc_r + PC_INC;
      end
   end

   // Fetch-stage registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r        <= RESET_PC;
         ir_r        <= '0;
         ir_pc_r     <= '0;
         ir_valid_r  <= 1'b0;
         fetch_err_r <= 1'b0;
         halted_r    <= 1'b0;
      end else begin
         pc_r        <= pc_nxt_s;
         ir_r        <= ir_nxt_s;
         ir_pc_r     <= ir_pc_nxt_s;
         ir_valid_r  <= ir_valid_nxt_s;
         fetch_err_r <= fetch_err_nxt_s;
         halted_r    <= halted_nxt_s;
      end
   end

   assign pc        = pc_r;
   assign ir        = ir_r;
   assign ir_pc     = ir_pc_r;
   assign ir_valid  = ir_valid_r;
   assign fetch_err = fetch_err_r;
   // Tied to zero when halt detection is compiled out.
   assign halted    = halted_r & HALT_EN;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// Testbench for instr_fetch_unit: directed scenarios with constant
// expectations plus randomized traffic checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

`ifdef HALT_DETECT_EN
   localparam bit HALT_ON = 1'b1;
`else
   localparam bit HALT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: default parameters
   logic        rst, prog_wr, pc_wr, stall;
   logic [15:0] prog_addr, prog_data, pc_in;
   logic [15:0] ir, ir_pc, pc;
   logic        ir_valid, fetch_err, halted;

   // DUT B: 8-bit PC with a full 256-word store (wrap check)
   logic        rst_b, prog_wr_b, pc_wr_b, stall_b;
   logic [7:0]  prog_addr_b, pc_in_b, ir_pc_b, pc_b;
   logic [15:0] prog_data_b, ir_b;
   logic        ir_valid_b, fetch_err_b, halted_b;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_unit dut (
      .clk(clk), .rst(rst), .prog_wr(prog_wr), .prog_addr(prog_addr),
      .prog_data(prog_data), .pc_wr(pc_wr), .pc_in(pc_in), .stall(stall),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .pc(pc),
      .fetch_err(fetch_err), .halted(halted)
   );

   instr_fetch_unit #(.ADDR_W(8), .DEPTH(256)) dut_b (
      .clk(clk), .rst(rst_b), .prog_wr(prog_wr_b), .prog_addr(prog_addr_b),
      .prog_data(prog_data_b), .pc_wr(pc_wr_b), .pc_in(pc_in_b), .stall(stall_b),
      .ir(ir_b), .ir_pc(ir_pc_b), .ir_valid(ir_valid_b), .pc(pc_b),
      .fetch_err(fetch_err_b), .halted(halted_b)
   );

   // ---------------- behavioural reference model for DUT A ----------------
   logic [15:0] mem_m [0:255];
   logic [15:0] m_pc, m_ir, m_ir_pc, m_w;
   logic        m_valid, m_err, m_halt;

   // Model one clock edge from the spec rules; fetch sees the old store word.
   always @(posedge clk) begin
      if (rst) begin
         m_pc = 16'd0; m_ir = 16'd0; m_ir_pc = 16'd0;
         m_valid = 1'b0; m_err = 1'b0; m_halt = 1'b0;
      end else if (pc_wr) begin
         m_pc = pc_in; m_valid = 1'b0; m_err = 1'b0; m_halt = 1'b0;
      end else if (!(stall || m_halt)) begin
         m_ir_pc = m_pc;
         m_valid = 1'b1;
         if (int'(m_pc) >= 256) begin
            m_ir  = 16'h0000;
            m_err = 1'b1;
            m_pc  = 16'((int'(m_pc) + 1) % 65536);
         end else begin
            m_w  = mem_m[int'(m_pc)];
            m_ir = m_w;
            if (HALT_ON && m_w == 16'hFFFF) m_halt = 1'b1;
            else m_pc = 16'((int'(m_pc) + 1) % 65536);
         end
      end
      if (prog_wr && int'(prog_addr) < 256) mem_m[int'(prog_addr)] = prog_data;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; prog_wr = 1'b0; pc_wr = 1'b0; stall = 1'b0;
      prog_addr = 16'd0; prog_data = 16'd0; pc_in = 16'd0;
   endtask

   // Reset while loading the whole store (writes are honoured during reset)
   task automatic test_reset();
      logic [15:0] init_w [4];
      init_w[0] = 16'hA8B7; init_w[1] = 16'h1111;
      init_w[2] = 16'h2222; init_w[3] = 16'h3333;
      idle();
      rst = 1'b1;
      prog_wr = 1'b1;
      for (int i = 0; i < 256; i++) begin
         prog_addr = 16'(i);
         prog_data = (i < 4) ? init_w[i] : 16'($urandom_range(0, 16'hFFFE));
         cyc();
      end
      prog_wr = 1'b0;
      cyc();
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 16'h0000); end
      n_checks++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h want %h", ir, 16'h0000); end
      n_checks++; if (ir_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_ir_pc: got %h want %h", ir_pc, 16'h0000); end
      n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid: got %b want 0", ir_valid); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
   endtask

   // Sequential fetch of the preloaded words after reset release
   task automatic test_seq_fetch();
      logic [15:0] exp_w [4];
      exp_w[0] = 16'hA8B7; exp_w[1] = 16'h1111;
      exp_w[2] = 16'h2222; exp_w[3] = 16'h3333;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_checks++; if (ir !== exp_w[i]) begin n_fail++; $display("FAIL seq_ir[%0d]: got %h want %h", i, ir, exp_w[i]); end
         n_checks++; if (ir_pc !== 16'(i)) begin n_fail++; $display("FAIL seq_ir_pc[%0d]: got %h want %h", i, ir_pc, 16'(i)); end
         n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, ir_valid); end
         n_checks++; if (pc !== 16'(i + 1)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 16'(i + 1)); end
      end
   endtask

   // Redirect produces a one-cycle bubble with IR held
   task automatic test_redirect();
      pc_wr = 1'b1; pc_in = 16'h0002;
      cyc();
      n_checks++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL redir_pc: got %h want %h", pc, 16'h0002); end
      n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got %b want 0", ir_valid); end
      n_checks++; if (ir !== 16'h3333) begin n_fail++; $display("FAIL redir_ir_hold: got %h want %h", ir, 16'h3333); end
      pc_wr = 1'b0;
      cyc();
      n_checks++; if (ir !== 16'h2222) begin n_fail++; $display("FAIL redir_ir: got %h want %h", ir, 16'h2222); end
      n_checks++; if (ir_pc !== 16'h0002) begin n_fail++; $display("FAIL redir_ir_pc: got %h want %h", ir_pc, 16'h0002); end
      n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid: got %b want 1", ir_valid); end
   endtask

   // Stall freezes the stage; pc_wr overrides stall
   task automatic test_stall_priority();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc, 16'h0003); end
         n_checks++; if (ir !== 16'h2222) begin n_fail++; $display("FAIL stall_ir[%0d]: got %h want %h", i, ir, 16'h2222); end
         n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, ir_valid); end
      end
      pc_wr = 1'b1; pc_in = 16'h0000;
      cyc();
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL stall_pcwr_pc: got %h want %h", pc, 16'h0000); end
      n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL stall_pcwr_valid: got %b want 0", ir_valid); end
      idle();
   endtask

   // Last in-range word, then NOP with sticky error until redirect
   task automatic test_out_of_range();
      logic [15:0] last_w;
      last_w = mem_m[255];
      pc_wr = 1'b1; pc_in = 16'h00FF;
      cyc();
      pc_wr = 1'b0;
      cyc();
      n_checks++; if (ir !== last_w) begin n_fail++; $display("FAIL oor_last_ir: got %h want %h", ir, last_w); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL oor_last_err: got %b want 0", fetch_err); end
      cyc();
      n_checks++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL oor_nop: got %h want %h", ir, 16'h0000); end
      n_checks++; if (ir_pc !== 16'h0100) begin n_fail++; $display("FAIL oor_ir_pc: got %h want %h", ir_pc, 16'h0100); end
      n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL oor_err_set: got %b want 1", fetch_err); end
      n_checks++; if (pc !== 16'h0101) begin n_fail++; $display("FAIL oor_pc_inc: got %h want %h", pc, 16'h0101); end
      stall = 1'b1;
      cyc();
      stall = 1'b0;
      cyc();
      n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL oor_err_sticky: got %b want 1", fetch_err); end
      pc_wr = 1'b1; pc_in = 16'h0000;
      cyc();
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear: got %b want 0", fetch_err); end
      idle();
   endtask

   // Same-address write/fetch is read-before-write; 8-bit PC wraps silently
   task automatic test_collision_wrap();
      logic [15:0] old_w;
      old_w = mem_m[5];
      pc_wr = 1'b1; pc_in = 16'h0005;
      cyc();
      pc_wr = 1'b0;
      prog_wr = 1'b1; prog_addr = 16'h0005; prog_data = 16'hBEEF;
      cyc();
      prog_wr = 1'b0;
      n_checks++; if (ir !== old_w) begin n_fail++; $display("FAIL coll_old: got %h want %h", ir, old_w); end
      pc_wr = 1'b1; pc_in = 16'h0005;
      cyc();
      pc_wr = 1'b0;
      cyc();
      n_checks++; if (ir !== 16'hBEEF) begin n_fail++; $display("FAIL coll_new: got %h want %h", ir, 16'hBEEF); end

      rst_b = 1'b1;
      cyc();
      rst_b = 1'b0;
      prog_wr_b = 1'b1; prog_addr_b = 8'hFF; prog_data_b = 16'h1357;
      pc_wr_b = 1'b1; pc_in_b = 8'hFF;
      cyc();
      prog_wr_b = 1'b0; pc_wr_b = 1'b0;
      n_checks++; if (pc_b !== 8'hFF) begin n_fail++; $display("FAIL wrap_load: got %h want %h", pc_b, 8'hFF); end
      cyc();
      n_checks++; if (pc_b !== 8'h00) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc_b, 8'h00); end
      n_checks++; if (ir_b !== 16'h1357) begin n_fail++; $display("FAIL wrap_ir: got %h want %h", ir_b, 16'h1357); end
      n_checks++; if (ir_pc_b !== 8'hFF) begin n_fail++; $display("FAIL wrap_ir_pc: got %h want %h", ir_pc_b, 8'hFF); end
      n_checks++; if (fetch_err_b !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b want 0", fetch_err_b); end
      n_checks++; if (halted_b !== 1'b0) begin n_fail++; $display("FAIL wrap_halted: got %b want 0", halted_b); end
   endtask

   // Halt word at address 3: halt and park, or ordinary word when compiled out
   task automatic test_halt();
      prog_wr = 1'b1; prog_addr = 16'h0003; prog_data = 16'hFFFF;
      pc_wr = 1'b1; pc_in = 16'h0000;
      cyc();
      idle();
      repeat (4) cyc();
      n_checks++; if (ir !== 16'hFFFF) begin n_fail++; $display("FAIL halt_ir: got %h want %h", ir, 16'hFFFF); end
      if (HALT_ON) begin
         for (int i = 0; i < 5; i++) begin
            n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag[%0d]: got %b want 1", i, halted); end
            n_checks++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL halt_pc[%0d]: got %h want %h", i, pc, 16'h0003); end
            cyc();
         end
         pc_wr = 1'b1; pc_in = 16'h0000;
         cyc();
         pc_wr = 1'b0;
         n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b want 0", halted); end
         cyc();
         n_checks++; if (ir !== 16'hA8B7) begin n_fail++; $display("FAIL halt_resume_ir: got %h want %h", ir, 16'hA8B7); end
         n_checks++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL halt_resume_pc: got %h want %h", pc, 16'h0001); end
      end else begin
         n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL nohalt_flag: got %b want 0", halted); end
         n_checks++; if (pc !== 16'h0004) begin n_fail++; $display("FAIL nohalt_pc: got %h want %h", pc, 16'h0004); end
      end
   endtask

   // Random mix of reset, redirect, stall and program writes vs the model
   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst     = ($urandom_range(0, 59) == 0);
         pc_wr   = ($urandom_range(0, 7) == 0);
         stall   = ($urandom_range(0, 3) == 0);
         prog_wr = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0: pc_in = 16'($urandom_range(0, 300));
            1: pc_in = 16'($urandom_range(250, 260));
            2: pc_in = 16'($urandom_range(16'hFFF8, 16'hFFFF));
            default: pc_in = 16'($urandom_range(0, 7));
         endcase
         prog_addr = 16'($urandom_range(0, 300));
         prog_data = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
         cyc();
         n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
         n_checks++; if (ir !== m_ir) begin n_fail++; $display("FAIL rnd_ir[%0d]: got %h want %h", i, ir, m_ir); end
         n_checks++; if (ir_pc !== m_ir_pc) begin n_fail++; $display("FAIL rnd_ir_pc[%0d]: got %h want %h", i, ir_pc, m_ir_pc); end
         n_checks++; if (ir_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, ir_valid, m_valid); end
         n_checks++; if (fetch_err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, fetch_err, m_err); end
         n_checks++; if (halted !== m_halt) begin n_fail++; $display("FAIL rnd_halted[%0d]: got %b want %b", i, halted, m_halt); end
      end
      idle();
   endtask

   initial begin
      idle();
      rst_b = 1'b1; prog_wr_b = 1'b0; pc_wr_b = 1'b0; stall_b = 1'b0;
      prog_addr_b = 8'h00; prog_data_b = 16'h0000; pc_in_b = 8'h00;
      test_reset();
      test_seq_fetch();
      test_redirect();
      test_stall_priority();
      test_out_of_range();
      test_collision_wrap();
      test_halt();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
